rst_release_seq: RTL

//  Consumes the system reset (rst) and a reset request (rst_req) and drives NUM_STAGES

---
 rtl/rst_release_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rst_release_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rst_release_seq
//  Purpose  : Holds NUM_STAGES domain resets asserted after the system reset
//             or a reset request, then releases them in order 0..N-1 with a
//             fixed gap. Also measures each request's length and flags
//             requests shorter than MIN_REQ.
//  Revision : 1.0 - initial release
// ============================================================================
module rst_release_seq #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 2,
  parameter int MIN_REQ     = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk_fr,
  input  logic                  rst,
  input  logic                  rst_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_done,
  output logic                  short_req_err,
  output logic [CNT_W-1:0]      req_len
);

  localparam int REL_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_MIN_REQ   = CNT_W'(MIN_REQ);
  localparam logic [REL_W-1:0] c_REL_ALL   = REL_W'(NUM_STAGES);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                r_state,    w_state_nxt;
  logic [CNT_W-1:0]      r_hold_cnt, w_hold_nxt;
  logic [CNT_W-1:0]      r_gap_cnt,  w_gap_nxt;
  logic [REL_W-1:0]      r_rel_cnt,  w_rel_nxt;   // number of stages released
  logic [CNT_W-1:0]      r_len_cnt,  w_len_nxt;
  logic [CNT_W-1:0]      r_req_len,  w_req_len_nxt;
  logic                  r_err,      w_err_nxt;
  logic                  r_done,     w_done_nxt;
  logic [NUM_STAGES-1:0] r_stage_rst, w_stage_nxt;

  // Register all state and outputs; rst wins over every other event.
  always_ff @(posedge clk_fr) begin
    if (rst) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_len_cnt   <= '0;
      r_req_len   <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_stage_rst <= '1;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_rel_cnt   <= w_rel_nxt;
      r_len_cnt   <= w_len_nxt;
      r_req_len   <= w_req_len_nxt;
      r_err       <= w_err_nxt;
      r_done      <= w_done_nxt;
      r_stage_rst <= w_stage_nxt;
    end
  end

  // Next-state logic for the release sequencer and the request-length monitor.
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_rel_nxt     = r_rel_cnt;
    w_done_nxt    = r_done;
    w_len_nxt     = r_len_cnt;
    w_req_len_nxt = r_req_len;
    w_err_nxt     = r_err;
    w_stage_nxt   = '1;

    case (r_state)
      ST_HOLD: begin
        w_done_nxt = 1'b0;
        w_rel_nxt  = '0;
        w_gap_nxt  = '0;
        if (rst_req) begin
          w_hold_nxt = '0;
        end else if (r_hold_cnt == c_HOLD_LAST) begin
          // Stage 0 drops on the same edge that leaves HOLD.
          w_state_nxt = ST_RELEASE;
          w_rel_nxt   = REL_W'(1);
          w_hold_nxt  = '0;
        end else if (r_hold_cnt != c_CNT_MAX) begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (rst_req) begin
          w_state_nxt = ST_HOLD;
          w_rel_nxt   = '0;
          w_gap_nxt   = '0;
          w_hold_nxt  = '0;
          w_done_nxt  = 1'b0;
        end else if (r_rel_cnt == c_REL_ALL) begin
          // seq_done follows one edge after the last stage falls.
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else if (r_gap_cnt == c_GAP_LAST) begin
          w_rel_nxt = r_rel_cnt + 1'b1;
          w_gap_nxt = '0;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (rst_req) begin
          w_state_nxt = ST_HOLD;
          w_rel_nxt   = '0;
          w_gap_nxt   = '0;
          w_hold_nxt  = '0;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_rel_nxt   = '0;
        w_gap_nxt   = '0;
        w_hold_nxt  = '0;
        w_done_nxt  = 1'b0;
      end
    endcase

    // Stages are derived from the release count, so a released stage always
    // has every lower-numbered stage released too.
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_stage_nxt[i] = (REL_W'(i) >= w_rel_nxt);
    end

    // A non-zero length count means the previous edge sampled rst_req high.
    if (rst_req) begin
      if (r_len_cnt != c_CNT_MAX) begin
        w_len_nxt = r_len_cnt + 1'b1;
      end
    end else begin
      w_len_nxt = '0;
      if (r_len_cnt != '0) begin
        w_req_len_nxt = r_len_cnt;
        if (r_len_cnt < c_MIN_REQ) begin
          w_err_nxt = 1'b1;
        end
      end
    end
  end

  assign stage_rst     = r_stage_rst;
  assign seq_done      = r_done;
  assign short_req_err = r_err;
  assign req_len       = r_req_len;

endmodule
`default_nettype wire
